// File: rtl/ram_port_ctrl.sv
// Front end for the two-port memory experiment: four debounced buttons, switch
// data latching, and one write FSM per memory port. Port B holds off any write
// that targets the address port A is currently setting up or writing.
module ram_port_ctrl #(
    parameter int unsigned AW        = 4,
    parameter int unsigned DW        = 4,
    parameter int unsigned DB_CYCLES = 1_000_000,
    parameter int unsigned WE_HOLD   = 100_000_000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          btn_wr_a,
    input  logic          btn_inc_a,
    input  logic          btn_wr_b,
    input  logic          btn_inc_b,
    input  logic [DW-1:0] sw_din_a,
    input  logic [DW-1:0] sw_din_b,
    output logic          we_a,
    output logic [AW-1:0] addr_a,
    output logic [DW-1:0] din_a,
    output logic          we_b,
    output logic [AW-1:0] addr_b,
    output logic [DW-1:0] din_b,
    output logic          stall_b,
    output logic [7:0]    coll_cnt
);

    localparam int unsigned DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned HW  = (WE_HOLD > 1) ? $clog2(WE_HOLD) : 1;
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(WE_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WRITE,
        DONE
    } state_t;

    // ---------------- button debouncers ----------------
    // Bit order: 0 wr_a, 1 inc_a, 2 wr_b, 3 inc_b.
    logic [3:0]     btn_raw;
    logic [3:0]     sync_q, sync_d;
    logic [3:0]     filt_q, filt_d;
    logic [3:0]     pulse_q, pulse_d;
    logic [DBW-1:0] db_cnt_q [4];
    logic [DBW-1:0] db_cnt_d [4];

    assign btn_raw = {btn_inc_b, btn_wr_b, btn_inc_a, btn_wr_a};

    // Count cycles the sampled button differs from its filtered level; any return
    // to the filtered level restarts the count. Rising filtered edge -> one pulse.
    always_comb begin
        sync_d  = btn_raw;
        filt_d  = filt_q;
        pulse_d = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (sync_q[i] != filt_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    filt_d[i] = sync_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
            pulse_d[i] = filt_d[i] & ~filt_q[i];
        end
    end

    // Debouncer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            filt_q  <= '0;
            pulse_q <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync_q  <= sync_d;
            filt_q  <= filt_d;
            pulse_q <= pulse_d;
            for (int unsigned i = 0; i < 4; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    logic wr_a_p, inc_a_p, wr_b_p, inc_b_p;
    assign wr_a_p  = pulse_q[0];
    assign inc_a_p = pulse_q[1];
    assign wr_b_p  = pulse_q[2];
    assign inc_b_p = pulse_q[3];

    // ---------------- write FSMs ----------------
    state_t          state_a_q, state_a_d;
    state_t          state_b_q, state_b_d;
    logic [AW-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [DW-1:0]   din_a_q, din_a_d, din_b_q, din_b_d;
    logic            we_a_q, we_a_d, we_b_q, we_b_d;
    logic [HW-1:0]   hold_a_q, hold_a_d, hold_b_q, hold_b_d;
    logic [7:0]      coll_q, coll_d;
    logic            stall_q, stall_d;
    logic            a_blocks_b;
    logic            stall_b_c;

    assign a_blocks_b = ((state_a_q == SETUP) || (state_a_q == WRITE)) &&
                        (addr_a_q == addr_b_q);
    assign stall_b_c  = (state_b_q == SETUP) && a_blocks_b;

    // State and datapath registers; reset aborts any write in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_a_q <= IDLE;
            state_b_q <= IDLE;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            din_a_q   <= '0;
            din_b_q   <= '0;
            we_a_q    <= 1'b0;
            we_b_q    <= 1'b0;
            hold_a_q  <= '0;
            hold_b_q  <= '0;
            coll_q    <= '0;
            stall_q   <= 1'b0;
        end else begin
            state_a_q <= state_a_d;
            state_b_q <= state_b_d;
            addr_a_q  <= addr_a_d;
            addr_b_q  <= addr_b_d;
            din_a_q   <= din_a_d;
            din_b_q   <= din_b_d;
            we_a_q    <= we_a_d;
            we_b_q    <= we_b_d;
            hold_a_q  <= hold_a_d;
            hold_b_q  <= hold_b_d;
            coll_q    <= coll_d;
            stall_q   <= stall_d;
        end
    end

    // Next-state logic for both ports; B waits in SETUP while A owns its address.
    always_comb begin
        state_a_d = state_a_q;
        unique case (state_a_q)
            IDLE:    if (wr_a_p) state_a_d = SETUP;
            SETUP:   state_a_d = WRITE;
            WRITE:   if (hold_a_q == HOLD_LAST) state_a_d = DONE;
            DONE:    state_a_d = IDLE;
            default: state_a_d = IDLE;
        endcase

        state_b_d = state_b_q;
        unique case (state_b_q)
            IDLE:    if (wr_b_p) state_b_d = SETUP;
            SETUP:   if (!a_blocks_b) state_b_d = WRITE;
            WRITE:   if (hold_b_q == HOLD_LAST) state_b_d = DONE;
            DONE:    state_b_d = IDLE;
            default: state_b_d = IDLE;
        endcase
    end

    // Datapath/output updates: address steps, data latch, hold counter, collisions.
    // we_x is registered from the next state so it is high exactly in WRITE.
    always_comb begin
        addr_a_d = addr_a_q;
        din_a_d  = din_a_q;
        hold_a_d = '0;
        unique case (state_a_q)
            IDLE:    if (!wr_a_p && inc_a_p) addr_a_d = addr_a_q + 1'b1;
            SETUP:   din_a_d = sw_din_a;
            WRITE:   hold_a_d = (hold_a_q == HOLD_LAST) ? '0 : hold_a_q + 1'b1;
            DONE:    addr_a_d = addr_a_q + 1'b1;
            default: ;
        endcase
        we_a_d = (state_a_d == WRITE);

        addr_b_d = addr_b_q;
        din_b_d  = din_b_q;
        hold_b_d = '0;
        unique case (state_b_q)
            IDLE:    if (!wr_b_p && inc_b_p) addr_b_d = addr_b_q + 1'b1;
            SETUP:   din_b_d = sw_din_b;
            WRITE:   hold_b_d = (hold_b_q == HOLD_LAST) ? '0 : hold_b_q + 1'b1;
            DONE:    addr_b_d = addr_b_q + 1'b1;
            default: ;
        endcase
        we_b_d = (state_b_d == WRITE);

        stall_d = stall_b_c;
        coll_d  = coll_q;
        if (stall_b_c && !stall_q && (coll_q != 8'hFF)) begin
            coll_d = coll_q + 1'b1;
        end
    end

    assign we_a     = we_a_q;
    assign addr_a   = addr_a_q;
    assign din_a    = din_a_q;
    assign we_b     = we_b_q;
    assign addr_b   = addr_b_q;
    assign din_b    = din_b_q;
    assign stall_b  = stall_b_c;
    assign coll_cnt = coll_q;

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Bench for ram_port_ctrl with DB_CYCLES=4, WE_HOLD=8. Expected writes are queued
// per port by the stimulus; a negedge monitor pops one per completed we pulse.
module tb_ram_port_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = '0;          // 0 wr_a, 1 inc_a, 2 wr_b, 3 inc_b
    logic [3:0] sw_a = '0;
    logic [3:0] sw_b = '0;
    logic       we_a, we_b, stall_b;
    logic [3:0] addr_a, addr_b, din_a, din_b;
    logic [7:0] coll_cnt;

    localparam logic [3:0] WR_A  = 4'b0001;
    localparam logic [3:0] INC_A = 4'b0010;
    localparam logic [3:0] WR_B  = 4'b0100;
    localparam logic [3:0] INC_B = 4'b1000;

    ram_port_ctrl #(.AW(4), .DW(4), .DB_CYCLES(4), .WE_HOLD(8)) dut (
        .clk(clk), .rst(rst),
        .btn_wr_a(btn[0]), .btn_inc_a(btn[1]), .btn_wr_b(btn[2]), .btn_inc_b(btn[3]),
        .sw_din_a(sw_a), .sw_din_b(sw_b),
        .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
        .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
        .stall_b(stall_b), .coll_cnt(coll_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0] addr;
        logic [3:0] din;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor state per port (0 = A, 1 = B).
    logic act[2]   = '{1'b0, 1'b0};
    int   len[2]   = '{0, 0};
    exp_t cap[2];
    logic moved[2] = '{1'b0, 1'b0};

    task automatic mon(input int p, input logic we, input logic [3:0] addr, input logic [3:0] din);
        exp_t e;
        int   qs;
        if (rst) begin
            act[p] = 1'b0;
        end else if (we) begin
            if (!act[p]) begin
                act[p]   = 1'b1;
                len[p]   = 1;
                cap[p]   = {addr, din};
                moved[p] = 1'b0;
            end else begin
                len[p]++;
                if ({addr, din} !== cap[p]) moved[p] = 1'b1;
            end
        end else if (act[p]) begin
            act[p] = 1'b0;
            qs = (p == 0) ? q_a.size() : q_b.size();
            if (qs == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write port%0d: got write addr=%0h din=%0h expected none",
                         p, cap[p].addr, cap[p].din);
            end else begin
                e = (p == 0) ? q_a.pop_front() : q_b.pop_front();
                check((p == 0) ? "wr_addr_a" : "wr_addr_b", 32'(cap[p].addr), 32'(e.addr));
                check((p == 0) ? "wr_din_a" : "wr_din_b", 32'(cap[p].din), 32'(e.din));
                check((p == 0) ? "we_len_a" : "we_len_b", 32'(len[p]), 32'd8);
                check((p == 0) ? "stable_a" : "stable_b", 32'(moved[p]), 32'd0);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, we_a, addr_a, din_a);
        mon(1, we_b, addr_b, din_b);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] mask);
        btn = mask;
        tick(6);
        btn = '0;
        tick(8);
    endtask

    task automatic wait_we_a(input string name);
        int n = 0;
        while (we_a !== 1'b1 && n < 30) begin
            tick(1);
            n++;
        end
        check(name, 32'(we_a), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        // ---- 1: reset state, then reset aborting a write ----
        tick(2);
        check("rst_we_a", 32'(we_a), 32'd0);
        check("rst_we_b", 32'(we_b), 32'd0);
        check("rst_addr_a", 32'(addr_a), 32'd0);
        check("rst_addr_b", 32'(addr_b), 32'd0);
        check("rst_stall", 32'(stall_b), 32'd0);
        check("rst_coll", 32'(coll_cnt), 32'd0);
        rst = 1'b0;
        tick(2);
        press(INC_A);
        check("t1_inc_a", 32'(addr_a), 32'd1);
        sw_a = 4'h6;
        btn  = WR_A;
        tick(6);
        btn  = '0;
        wait_we_a("t1_we_rise");
        tick(3);
        #2 rst = 1'b1;
        #1;
        check("t1_abort_we_a", 32'(we_a), 32'd0);
        check("t1_abort_addr_a", 32'(addr_a), 32'd0);
        check("t1_abort_din_a", 32'(din_a), 32'd0);
        check("t1_abort_coll", 32'(coll_cnt), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(10);

        // ---- 2: bouncing write button -> single write ----
        sw_a = 4'hA;
        q_a.push_back('{addr: 4'h0, din: 4'hA});
        for (int i = 0; i < 10; i++) begin
            btn[0] = (i % 2 == 0);
            tick(2);
        end
        btn[0] = 1'b1;
        tick(6);
        btn[0] = 1'b0;
        tick(20);
        check("t2_addr_after", 32'(addr_a), 32'd1);

        // ---- 3: 16 increments on B wrap to 0, no writes ----
        for (int i = 0; i < 16; i++) begin
            press(INC_B);
            if (i == 0)  check("t3_addr_b_1", 32'(addr_b), 32'd1);
            if (i == 14) check("t3_addr_b_15", 32'(addr_b), 32'd15);
        end
        check("t3_wrap", 32'(addr_b), 32'd0);

        // ---- 4: same-address race at 5 ----
        for (int i = 0; i < 4; i++) press(INC_A | INC_B);
        press(INC_B);
        check("t4_addr_a", 32'(addr_a), 32'd5);
        check("t4_addr_b", 32'(addr_b), 32'd5);
        sw_a = 4'h3;
        sw_b = 4'h9;
        q_a.push_back('{addr: 4'h5, din: 4'h3});
        q_b.push_back('{addr: 4'h5, din: 4'h9});
        btn = WR_A | WR_B;
        tick(6);
        btn = '0;
        wait_we_a("t4_we_a_rise");
        for (int k = 0; k < 8; k++) begin
            check("t4_stall_during_a", 32'(stall_b), 32'd1);
            check("t4_we_b_held", 32'(we_b), 32'd0);
            tick(1);
        end
        check("t4_we_a_end", 32'(we_a), 32'd0);
        check("t4_we_b_not_yet", 32'(we_b), 32'd0);
        tick(1);
        check("t4_we_b_rise", 32'(we_b), 32'd1);
        check("t4_stall_clear", 32'(stall_b), 32'd0);
        tick(12);
        check("t4_coll", 32'(coll_cnt), 32'd1);
        check("t4_addr_a_end", 32'(addr_a), 32'd6);
        check("t4_addr_b_end", 32'(addr_b), 32'd6);

        // ---- 5: different addresses 2 and 7 write concurrently ----
        press(INC_A | INC_B);
        for (int i = 0; i < 11; i++) press(INC_A);
        check("t5_addr_a", 32'(addr_a), 32'd2);
        check("t5_addr_b", 32'(addr_b), 32'd7);
        sw_a = 4'hC;
        sw_b = 4'h5;
        q_a.push_back('{addr: 4'h2, din: 4'hC});
        q_b.push_back('{addr: 4'h7, din: 4'h5});
        btn = WR_A | WR_B;
        tick(6);
        btn = '0;
        wait_we_a("t5_we_a_rise");
        for (int k = 0; k < 8; k++) begin
            check("t5_we_b_overlap", 32'(we_b), 32'd1);
            check("t5_no_stall", 32'(stall_b), 32'd0);
            tick(1);
        end
        tick(12);
        check("t5_coll_unchanged", 32'(coll_cnt), 32'd1);
        check("t5_addr_a_end", 32'(addr_a), 32'd3);
        check("t5_addr_b_end", 32'(addr_b), 32'd8);

        // ---- 6: second press landing during WRITE is dropped ----
        sw_a = 4'h7;
        q_a.push_back('{addr: 4'h3, din: 4'h7});
        btn[0] = 1'b1;
        tick(4);
        btn[0] = 1'b0;
        tick(4);
        check("t6_busy", 32'(we_a), 32'd1);
        btn[0] = 1'b1;
        tick(8);
        btn[0] = 1'b0;
        tick(24);
        check("t6_addr_a_end", 32'(addr_a), 32'd4);

        tick(4);
        check("pending_a", 32'(q_a.size()), 32'd0);
        check("pending_b", 32'(q_b.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
